// File: rtl/mem_stage_pkg.sv
// Shared opcodes, constants and FSM encoding for the MEM stage and its helpers.
package mem_stage_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'd0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        RstEnable    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

  function automatic logic op_is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic op_is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  // Big-endian lanes: offset 0 is the most significant byte.
  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] off);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: lane_sel = 4'b1000 >> off;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: lane_sel = off[1] ? 4'b0011 : 4'b1100;
      default:                          lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misaligned = off[0];
      EXE_LW_OP, EXE_SW_OP:             misaligned = |off;
      default:                          misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus: registered request side from the MEM stage, read data + one-cycle ack back.
interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [3:0]        sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, sel, addr, wdata, input rdata, ack);
  modport slave  (input req, we, sel, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage_load_align.sv
// Big-endian lane select and sign/zero extension of a bus read word.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [7:0]  aluop_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[31:24];
      2'd1:    byte_sel = rdata_i[23:16];
      2'd2:    byte_sel = rdata_i[15:8];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    case (aluop_i)
      EXE_LB_OP:  data_o = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: data_o = {24'h0, byte_sel};
      EXE_LH_OP:  data_o = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: data_o = {16'h0, half_sel};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-bus loads/stores, formats load data and stalls the pipe while an access is outstanding.
// MEM/WB cannot stall, so every stalled cycle is presented to it as a bubble.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_write,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [ADDR_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic                  flush,
  mem_stage_if.master           dbus,
  output logic                  stall_req,
  output logic [REG_ADDR_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic                  mem_write_o,
  output logic                  align_exc_o
);

  mem_state_e        state_q;
  logic              flush_pend_q;
  logic              req_q, we_q;
  logic [3:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              is_ld, is_st, is_mem, misal, issue;

  assign is_ld  = op_is_load(ex_aluop);
  assign is_st  = op_is_store(ex_aluop);
  assign is_mem = is_ld | is_st;
  assign misal  = is_mem & misaligned(ex_aluop, ex_mem_addr[1:0]);
  assign issue  = (state_q == ST_IDLE) & is_mem & ~misal & ~flush;
  assign sel_d  = lane_sel(ex_aluop, ex_mem_addr[1:0]);

  always_comb begin
    case (ex_aluop)
      EXE_SB_OP: wdata_d = {4{ex_store_data[7:0]}};
      EXE_SH_OP: wdata_d = {2{ex_store_data[15:0]}};
      default:   wdata_d = ex_store_data;
    endcase
  end

  mem_load_align u_load_align (
    .rdata_i (dbus.rdata),
    .addr_i  (ex_mem_addr[1:0]),
    .aluop_i (ex_aluop),
    .data_o  (ld_data_d)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q      <= ST_IDLE;
      flush_pend_q <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 4'b0000;
      addr_q       <= '0;
      wdata_q      <= '0;
      ld_data_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            req_q        <= 1'b1;
            we_q         <= is_st;
            sel_q        <= sel_d;
            addr_q       <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
            wdata_q      <= wdata_d;
            flush_pend_q <= 1'b0;
            state_q      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A flush cannot abort the bus cycle; it only suppresses the writeback.
          if (dbus.ack) begin
            req_q        <= 1'b0;
            ld_data_q    <= ld_data_d;
            flush_pend_q <= 1'b0;
            state_q      <= (flush_pend_q | flush) ? ST_IDLE : ST_HOLD;
          end else if (flush) begin
            flush_pend_q <= 1'b1;
          end
        end
        ST_HOLD: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.sel   = sel_q;
  assign dbus.addr  = addr_q;
  assign dbus.wdata = wdata_q;

  always_comb begin
    stall_req   = 1'b0;
    mem_waddr_o = ex_waddr;
    mem_wdata_o = ex_wdata;
    mem_write_o = ex_write;
    if (rst == RstEnable) begin
      mem_waddr_o = NOPRegAddr;
      mem_wdata_o = ZeroWord;
      mem_write_o = WriteDisable;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (misal) begin
            mem_write_o = WriteDisable;
          end else if (issue) begin
            stall_req   = 1'b1;
            mem_waddr_o = NOPRegAddr;
            mem_wdata_o = ZeroWord;
            mem_write_o = WriteDisable;
          end
        end
        ST_BUSY: begin
          stall_req   = 1'b1;
          mem_waddr_o = NOPRegAddr;
          mem_wdata_o = ZeroWord;
          mem_write_o = WriteDisable;
        end
        ST_HOLD: begin
          if (is_ld) mem_wdata_o = ld_data_q;
        end
        default: ;
      endcase
    end
  end

  assign align_exc_o = (rst != RstEnable) & misal;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed multi-cycle sequences and randomized transactions.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        ex_write;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        flush;
  logic        stall_req;
  logic [4:0]  mem_waddr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_write_o;
  logic        align_exc_o;

  mem_stage_if #(.ADDR_W(32), .DATA_W(32)) dbus_if ();

  mem_stage #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5), .ALUOP_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_waddr      (ex_waddr),
    .ex_wdata      (ex_wdata),
    .ex_write      (ex_write),
    .ex_aluop      (ex_aluop),
    .ex_mem_addr   (ex_mem_addr),
    .ex_store_data (ex_store_data),
    .flush         (flush),
    .dbus          (dbus_if),
    .stall_req     (stall_req),
    .mem_waddr_o   (mem_waddr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_write_o   (mem_write_o),
    .align_exc_o   (align_exc_o)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] NOP_OP = 8'h00;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
      default:                          return 4;
    endcase
  endfunction

  function automatic logic m_misal(input logic [7:0] op, input logic [31:0] addr);
    return (addr % 32'(m_size(op))) != 32'd0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
    int off = int'(addr % 32'd4);
    int s   = m_size(op);
    logic [3:0] sel = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + s) sel[3-i] = 1'b1;
    return sel;
  endfunction

  function automatic logic [31:0] m_bwdata(input logic [7:0] op, input logic [31:0] sd);
    case (m_size(op))
      1:       return {24'h0, sd[7:0]} * 32'h0101_0101;
      2:       return {16'h0, sd[15:0]} * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int off = int'(addr % 32'd4);
    int s   = m_size(op);
    logic [31:0] mask, v;
    if (s == 4) return rd;
    mask = (32'd1 << (8 * s)) - 32'd1;
    v    = (rd >> (8 * (4 - off - s))) & mask;
    if ((op == EXE_LB_OP || op == EXE_LH_OP) && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // One aligned load/store from IDLE through HOLD back to IDLE; ack after `delay` wait cycles in BUSY.
  task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rd, input int delay, input logic [4:0] wa,
                         input logic [31:0] wd, input logic we,
                         output logic [3:0] b_sel, output logic [31:0] b_addr,
                         output logic [31:0] b_wdata, output logic b_we, output logic seq_ok,
                         output int stalls, output logic [4:0] h_wa, output logic [31:0] h_wd,
                         output logic h_wr);
    ex_aluop = op; ex_mem_addr = addr; ex_store_data = sd;
    ex_waddr = wa; ex_wdata = wd; ex_write = we; flush = 1'b0; dbus_if.ack = 1'b0;
    stalls = 0;
    #2;
    stalls += int'(stall_req);
    seq_ok = ~mem_write_o & ~align_exc_o;
    step();
    b_sel = dbus_if.sel; b_addr = dbus_if.addr; b_wdata = dbus_if.wdata; b_we = dbus_if.we;
    for (int d = 0; d < delay; d++) begin
      #2;
      stalls += int'(stall_req);
      seq_ok &= dbus_if.req & ~mem_write_o & (dbus_if.sel == b_sel) & (dbus_if.addr == b_addr);
      step();
    end
    dbus_if.rdata = rd; dbus_if.ack = 1'b1;
    #2;
    stalls += int'(stall_req);
    seq_ok &= dbus_if.req & ~mem_write_o;
    step();
    dbus_if.ack = 1'b0; dbus_if.rdata = $urandom;
    #2;
    stalls += int'(stall_req);
    seq_ok &= ~dbus_if.req;
    h_wa = mem_waddr_o; h_wd = mem_wdata_o; h_wr = mem_write_o;
    step();
    ex_aluop = NOP_OP;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic        fl;
    logic        e_stall;
    logic        e_align;
    logic        e_write;
  } vec_t;

  vec_t        vt[11];
  logic [7:0]  ops[8];
  logic [3:0]  c_sel;
  logic [31:0] c_addr, c_wdata, c_hwd;
  logic        c_we, c_ok, c_hwr;
  logic [4:0]  c_hwa;
  int          c_stalls;
  logic [7:0]  r_op;
  logic [31:0] r_addr, r_sd, r_rd, r_wd;
  logic [4:0]  r_wa;
  logic        r_we, fl_ok;
  int          r_dly;

  initial begin
    vt[0]  = '{NOP_OP,     32'h0000, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{EXE_LW_OP,  32'h0006, 5'd3, 32'h1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{EXE_LH_OP,  32'h0011, 5'd3, 32'h2222, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{EXE_SH_OP,  32'h0013, 5'd0, 32'h3333, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{EXE_SW_OP,  32'h0022, 5'd0, 32'h4444, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{EXE_LW_OP,  32'h0024, 5'd6, 32'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{EXE_LB_OP,  32'h0033, 5'd7, 32'h6666, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{EXE_LW_OP,  32'h0028, 5'd8, 32'h7777, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{EXE_LHU_OP, 32'h002A, 5'd9, 32'h8888, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{8'h21,      32'h0000, 5'd2, 32'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{EXE_SB_OP,  32'h0001, 5'd0, 32'hAAAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

    // Reset: combinational outputs forced even with a misaligned load presented.
    rst = 1'b1; ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h6; ex_waddr = 5'd12; ex_wdata = 32'hDEAD;
    ex_write = 1'b1; ex_store_data = 32'h0; flush = 1'b0; dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0;
    step(); step();
    #2;
    chk("rst_stall", stall_req, 0);
    chk("rst_write", mem_write_o, 0);
    chk("rst_waddr", mem_waddr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_align", align_exc_o, 0);
    chk("rst_req", dbus_if.req, 0);
    chk("rst_sel", dbus_if.sel, 0);
    rst = 1'b0; ex_aluop = NOP_OP;
    step();

    // IDLE-cycle vector table; op is withdrawn before the edge so nothing issues.
    for (int i = 0; i < 11; i++) begin
      ex_aluop = vt[i].op; ex_mem_addr = vt[i].addr; ex_waddr = vt[i].wa;
      ex_wdata = vt[i].wd; ex_write = vt[i].we; flush = vt[i].fl;
      #2;
      chk($sformatf("vec%0d_stall", i), stall_req, vt[i].e_stall);
      chk($sformatf("vec%0d_align", i), align_exc_o, vt[i].e_align);
      chk($sformatf("vec%0d_write", i), mem_write_o, vt[i].e_write);
      if (!vt[i].e_stall && !vt[i].e_align) begin
        chk($sformatf("vec%0d_waddr", i), mem_waddr_o, vt[i].wa);
        chk($sformatf("vec%0d_wdata", i), mem_wdata_o, vt[i].wd);
      end
      ex_aluop = NOP_OP; flush = 1'b0;
      step();
      chk($sformatf("vec%0d_noreq", i), dbus_if.req, 0);
    end

    // LB at 0x103, ack in the second BUSY cycle.
    run_txn(EXE_LB_OP, 32'h103, 32'h0, 32'hAABBCC80, 1, 5'd4, 32'h0, 1'b1,
            c_sel, c_addr, c_wdata, c_we, c_ok, c_stalls, c_hwa, c_hwd, c_hwr);
    chk("lb_sel", c_sel, 4'b0001);
    chk("lb_addr", c_addr, 32'h100);
    chk("lb_we", c_we, 0);
    chk("lb_stall_cycles", c_stalls, 3);
    chk("lb_seq", c_ok, 1);
    chk("lb_hold_wdata", c_hwd, 32'hFFFFFF80);
    chk("lb_hold_write", c_hwr, 1);
    chk("lb_hold_waddr", c_hwa, 5'd4);
    run_txn(EXE_LBU_OP, 32'h103, 32'h0, 32'hAABBCC80, 1, 5'd4, 32'h0, 1'b1,
            c_sel, c_addr, c_wdata, c_we, c_ok, c_stalls, c_hwa, c_hwd, c_hwr);
    chk("lbu_hold_wdata", c_hwd, 32'h00000080);

    // SH at 0x202, ack in the first BUSY cycle.
    run_txn(EXE_SH_OP, 32'h202, 32'h0000BEEF, 32'h0, 0, 5'd0, 32'h77, 1'b0,
            c_sel, c_addr, c_wdata, c_we, c_ok, c_stalls, c_hwa, c_hwd, c_hwr);
    chk("sh_we", c_we, 1);
    chk("sh_sel", c_sel, 4'b0011);
    chk("sh_addr", c_addr, 32'h200);
    chk("sh_wdata", c_wdata, 32'hBEEFBEEF);
    chk("sh_stall_cycles", c_stalls, 2);
    chk("sh_hold_write", c_hwr, 0);
    chk("sh_hold_wdata", c_hwd, 32'h77);

    // LW with flush in the second BUSY cycle and ack in the fourth: no HOLD, no writeback.
    ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h40; ex_write = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h1;
    flush = 1'b0; dbus_if.ack = 1'b0; fl_ok = 1'b1;
    #2; fl_ok &= stall_req & ~mem_write_o; step();
    #2; fl_ok &= dbus_if.req & stall_req & ~mem_write_o; step(); flush = 1'b1;
    #2; fl_ok &= dbus_if.req & stall_req & ~mem_write_o; step(); flush = 1'b0;
    #2; fl_ok &= dbus_if.req & stall_req & ~mem_write_o; step();
    dbus_if.ack = 1'b1; dbus_if.rdata = 32'hCAFE0001;
    #2; fl_ok &= dbus_if.req & stall_req & ~mem_write_o; step();
    dbus_if.ack = 1'b0;
    chk("flush_busy_bubble", fl_ok, 1);
    #2;
    chk("flush_req_dropped", dbus_if.req, 0);
    chk("flush_no_hold_write", mem_write_o, 0);
    chk("flush_no_hold_stall", stall_req, 1);
    ex_aluop = NOP_OP; ex_write = 1'b0;
    step();
    chk("flush_idle_noreq", dbus_if.req, 0);

    // Reset in the middle of BUSY, then a late ack one cycle after reset releases.
    ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h80; ex_write = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h55;
    step();
    chk("rstbusy_req_before", dbus_if.req, 1);
    rst = 1'b1; ex_mem_addr = 32'h86;
    #2;
    chk("rstbusy_stall", stall_req, 0);
    chk("rstbusy_align", align_exc_o, 0);
    chk("rstbusy_write", mem_write_o, 0);
    step();
    chk("rstbusy_req_after", dbus_if.req, 0);
    chk("rstbusy_addr_after", dbus_if.addr, 0);
    rst = 1'b0; ex_aluop = NOP_OP; ex_mem_addr = 32'h80;
    step();
    dbus_if.ack = 1'b1; dbus_if.rdata = 32'h12345678;
    #2;
    chk("late_ack_stall", stall_req, 0);
    step();
    dbus_if.ack = 1'b0;
    #2;
    chk("late_ack_req", dbus_if.req, 0);
    chk("late_ack_passthru", mem_write_o, 1);
    ex_aluop = EXE_LW_OP;
    #2;
    chk("late_ack_idle", stall_req, 1);
    ex_aluop = NOP_OP;
    step();

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      r_op = ops[$urandom_range(0, 7)];
      r_addr = $urandom & 32'h0000FFFF;
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~(32'(m_size(r_op)) - 32'd1);
      r_sd = $urandom; r_rd = $urandom; r_wa = 5'($urandom); r_wd = $urandom;
      r_we = 1'($urandom); r_dly = $urandom_range(0, 3);
      if (m_misal(r_op, r_addr)) begin
        ex_aluop = r_op; ex_mem_addr = r_addr; ex_write = 1'b1; flush = 1'b0;
        #2;
        chk("rnd_misal_flag", align_exc_o, 1);
        chk("rnd_misal_stall", stall_req, 0);
        chk("rnd_misal_write", mem_write_o, 0);
        step();
        chk("rnd_misal_noreq", dbus_if.req, 0);
        ex_aluop = NOP_OP;
      end else begin
        run_txn(r_op, r_addr, r_sd, r_rd, r_dly, r_wa, r_wd, r_we,
                c_sel, c_addr, c_wdata, c_we, c_ok, c_stalls, c_hwa, c_hwd, c_hwr);
        chk("rnd_sel", c_sel, m_sel(r_op, r_addr));
        chk("rnd_addr", c_addr, r_addr & ~32'd3);
        chk("rnd_we", c_we, op_is_store(r_op));
        if (op_is_store(r_op)) chk("rnd_bus_wdata", c_wdata, m_bwdata(r_op, r_sd));
        chk("rnd_stall_cycles", c_stalls, 2 + r_dly);
        chk("rnd_seq", c_ok, 1);
        chk("rnd_hold_waddr", c_hwa, r_wa);
        chk("rnd_hold_write", c_hwr, r_we);
        chk("rnd_hold_wdata", c_hwd, op_is_load(r_op) ? m_load(r_op, r_addr, r_rd) : r_wd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage integer core.
- Sits between the EX/MEM pipeline register and the MEM/WB register, and drives the data-memory bus with a req/ack handshake.
- Formats load data: byte/half lane select plus sign/zero extension. Generates store byte enables.
- Requests a pipeline stall while a bus access is outstanding and flags misaligned accesses.
- Its mem_waddr_o/mem_wdata_o/mem_write_o outputs are sampled every cycle by the MEM/WB register. That register has no stall input, so this block emits a bubble while stalled.

Parameters:
- DATA_W, 32, datapath and bus data width.
- ADDR_W, 32, data-bus address width.
- REG_ADDR_W, 5, register-file address width.
- ALUOP_W, 8, aluop code width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_waddr  in  REG_ADDR_W  destination register from EX/MEM
- ex_wdata  in  DATA_W  ALU result from EX/MEM
- ex_write  in  1  register write enable from EX/MEM
- ex_aluop  in  ALUOP_W  operation code; load/store codes are defined in the package
- ex_mem_addr  in  ADDR_W  effective address
- ex_store_data  in  DATA_W  store source register value
- flush  in  1  pipeline flush from the control unit
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  1 = store, registered
- dbus_sel  out  4  byte enables, registered
- dbus_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00}), registered
- dbus_wdata  out  DATA_W  store data replicated into lanes, registered
- dbus_rdata  in  DATA_W  read data, valid with dbus_ack
- dbus_ack  in  1  one-cycle completion strobe
- stall_req  out  1  hold EX/MEM and earlier stages
- mem_waddr_o  out  REG_ADDR_W  to MEM/WB
- mem_wdata_o  out  DATA_W  to MEM/WB
- mem_write_o  out  1  to MEM/WB
- align_exc_o  out  1  misaligned access flag, combinational

Behaviour:
- Byte order is big-endian.
  - addr[1:0]=0 selects byte lane [31:24], dbus_sel 4'b1000.
  - Half at addr[1]=0 uses lanes [31:16], sel 4'b1100.
  - Word uses sel 4'b1111.
- Store data: SB replicates the byte into all 4 lanes; SH replicates the half into both halves; SW passes the word through.
- Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - align_exc_o=1; no bus request; mem_write_o=0; stall_req=0.
- States: IDLE, BUSY, HOLD. Reset value is IDLE.
- IDLE:
  - Non-memory aluop, or flush=1: outputs pass ex_* straight through; stall_req=0.
  - Aligned load/store and flush=0:
    - Combinationally: stall_req=1, mem_write_o=0.
    - At the clock edge: register the bus signals with dbus_req=1, then go to BUSY.
- BUSY:
  - dbus_req stays 1 and all bus signals are held stable until dbus_ack.
  - stall_req=1 and mem_write_o=0 (bubble).
  - On dbus_ack: dbus_req is cleared at that edge; the formatted load data is captured into ld_data_r.
  - Next state is HOLD, or IDLE if flush was seen at any point during BUSY (sticky flush_pend bit).
- HOLD (exactly 1 cycle):
  - stall_req=0; mem_waddr_o=ex_waddr; mem_write_o=ex_write.
  - mem_wdata_o=ld_data_r for loads, ex_wdata for stores.
  - MEM/WB captures these at the end of HOLD; next state is IDLE. The block never re-issues the same instruction.
- Load formatting:
  - LB/LBU: selected byte, sign- or zero-extended.
  - LH/LHU: selected half, sign- or zero-extended.
  - LW: full word.
- Minimum load/store latency is 3 cycles (IDLE, BUSY, HOLD) when ack arrives in the first BUSY cycle. There is no timeout; BUSY waits indefinitely.
- dbus_ack in IDLE or HOLD is ignored.
- Flush in BUSY cannot cancel the bus transaction. The block waits for ack, discards the data, and produces no writeback.
- Reset, including mid-BUSY:
  - State goes to IDLE; dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata, ld_data_r and flush_pend all go to 0.
  - A late ack arriving after reset is ignored.
- During reset the combinational outputs are forced: mem_waddr_o=0, mem_wdata_o=0, mem_write_o=0, stall_req=0, align_exc_o=0.

Decomposition:
- Shared package holds:
  - ALUOP codes for LB, LBU, LH, LHU, LW, SB, SH, SW.
  - Constants ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, RstEnable.
  - State encoding for IDLE/BUSY/HOLD.
- One sub-module, mem_load_align: a combinational lane select plus extension, taking rdata, addr[1:0] and aluop and returning a 32-bit result. It is instantiated once in front of ld_data_r.

Test Plan:
- ALU op (aluop non-mem, ex_waddr=5, ex_wdata=0x1234, ex_write=1) -> same cycle mem_*_o = 5/0x1234/1; stall_req=0; dbus_req stays 0.
- LB at addr 0x103, ack 2 cycles after req, rdata=0xAABBCC80 -> sel=4'b0001, addr=0x100; stall_req=1 for 3 cycles; HOLD mem_wdata_o=0xFFFFFF80; LBU of the same access gives 0x00000080.
- SH at addr 0x202, store_data=0x0000BEEF, ack in the first BUSY cycle -> dbus_we=1, sel=4'b0011, wdata=0xBEEFBEEF; HOLD mem_write_o equals ex_write (0).
- LW at addr 0x6 -> align_exc_o=1, dbus_req=0, stall_req=0, mem_write_o=0.
- LW issued; flush=1 in the second BUSY cycle; ack on the fourth -> dbus_req held until ack, then IDLE with no HOLD; mem_write_o stays 0 throughout.
- rst asserted mid-BUSY, then ack arrives 1 cycle after reset deasserts -> dbus_req=0 after the reset edge; the late ack is ignored; state stays IDLE.
